// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the two-requester memory arbiter/controller.
package mem_arb_pkg;

  localparam int unsigned DEPTH_DEF      = 4;
  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned TIMEOUT_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_e;

  typedef logic req_id_t;

  // One-hot pulse vector for a requester id.
  function automatic logic [1:0] id_onehot(input req_id_t id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin winner select; the pointer names the requester favoured on a tie
// and moves to the other requester whenever a grant is taken.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic       win_id_c_o,
  output logic       win_vld_c_o
);

  req_id_t ptr_q, ptr_d;

  always_comb begin
    win_vld_c_o = |req_i;
    win_id_c_o  = (req_i == 2'b11) ? ptr_q : req_i[1];
    ptr_d       = ptr_q;
    if (adv_i && win_vld_c_o) begin
      ptr_d = ~win_id_c_o;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mem_arb_ctrl.sv
// Two-requester memory arbiter and single-port memory sequencer (IDLE -> ISSUE -> WAIT_RD).
// Define ARB_TIMEOUT_EN to bound the read wait at TIMEOUT cycles and report rerr.
module mem_arb_ctrl
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [DEPTH-1:0]      addr0,
  input  logic [DEPTH-1:0]      addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic [1:0]            gnt,
  output logic [1:0]            rvalid,
  output logic [1:0]            rerr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  mem_EN,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  output logic [DEPTH-1:0]      mem_add,
  output logic [DATA_WIDTH-1:0] mem_Data_in,
  input  logic                  mem_valid_out,
  input  logic [DATA_WIDTH-1:0] mem_Data_out
);

  state_e                  state_q, state_d;
  req_id_t                 owner_q, owner_d;
  logic                    we_q, we_d;
  logic [DEPTH-1:0]        addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

  logic [1:0]              gnt_q, gnt_d;
  logic [1:0]              rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    busy_q, busy_d;
  logic                    mem_en_q, mem_en_d;
  logic                    mem_wr_q, mem_wr_d;
  logic                    mem_rd_q, mem_rd_d;
  logic [DEPTH-1:0]        mem_add_q, mem_add_d;
  logic [DATA_WIDTH-1:0]   mem_din_q, mem_din_d;

  logic                    win_id_c;
  logic                    win_vld_c;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [1:0]              rerr_q, rerr_d;
  logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
`endif

  // Pointer only advances when a grant is actually taken in IDLE.
  rr_arb2 u_rr_arb2 (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .adv_i       (state_q == IDLE),
    .win_id_c_o  (win_id_c),
    .win_vld_c_o (win_vld_c)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    gnt_d     = 2'b00;
    rvalid_d  = 2'b00;
    rdata_d   = rdata_q;
    mem_en_d  = 1'b0;
    mem_wr_d  = 1'b0;
    mem_rd_d  = 1'b0;
    mem_add_d = mem_add_q;
    mem_din_d = mem_din_q;
`ifdef ARB_TIMEOUT_EN
    rerr_d    = 2'b00;
    to_cnt_d  = '0;
`endif

    unique case (state_q)
      IDLE: begin
        if (win_vld_c) begin
          state_d = ISSUE;
          owner_d = win_id_c;
          gnt_d   = id_onehot(win_id_c);
          we_d    = we[win_id_c];
          addr_d  = win_id_c ? addr1 : addr0;
          wdata_d = win_id_c ? wdata1 : wdata0;
        end
      end
      // The strobe registered here is the single memory-enable cycle.
      ISSUE: begin
        mem_en_d  = 1'b1;
        mem_wr_d  = we_q;
        mem_rd_d  = ~we_q;
        mem_add_d = addr_q;
        mem_din_d = wdata_q;
        state_d   = we_q ? IDLE : WAIT_RD;
      end
      WAIT_RD: begin
        if (mem_valid_out) begin
          rdata_d  = mem_Data_out;
          rvalid_d = id_onehot(owner_q);
          state_d  = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          rerr_d  = id_onehot(owner_q);
          state_d = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      gnt_q     <= 2'b00;
      rvalid_q  <= 2'b00;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      mem_en_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_add_q <= '0;
      mem_din_q <= '0;
`ifdef ARB_TIMEOUT_EN
      rerr_q    <= 2'b00;
      to_cnt_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      gnt_q     <= gnt_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      mem_en_q  <= mem_en_d;
      mem_wr_q  <= mem_wr_d;
      mem_rd_q  <= mem_rd_d;
      mem_add_q <= mem_add_d;
      mem_din_q <= mem_din_d;
`ifdef ARB_TIMEOUT_EN
      rerr_q    <= rerr_d;
      to_cnt_q  <= to_cnt_d;
`endif
    end
  end

  assign gnt         = gnt_q;
  assign rvalid      = rvalid_q;
  assign rdata       = rdata_q;
  assign busy        = busy_q;
  assign mem_EN      = mem_en_q;
  assign mem_wr_en   = mem_wr_q;
  assign mem_rd_en   = mem_rd_q;
  assign mem_add     = mem_add_q;
  assign mem_Data_in = mem_din_q;
`ifdef ARB_TIMEOUT_EN
  assign rerr        = rerr_q;
`else
  assign rerr        = 2'b00;
`endif

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Bench for mem_arb_ctrl: timeline model of grants/issues/read completions, a per-cycle
// compare against it, a behavioural memory responder and directed literal checks.
module tb_mem_arb_ctrl;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned DW      = 32;
  localparam int unsigned TIMEOUT = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       req = 2'b00;
  logic [1:0]       we = 2'b00;
  logic [DEPTH-1:0] addr0 = '0;
  logic [DEPTH-1:0] addr1 = '0;
  logic [DW-1:0]    wdata0 = '0;
  logic [DW-1:0]    wdata1 = '0;
  logic [1:0]       gnt, rvalid, rerr;
  logic [DW-1:0]    rdata;
  logic             busy, mem_EN, mem_wr_en, mem_rd_en;
  logic [DEPTH-1:0] mem_add;
  logic [DW-1:0]    mem_Data_in;
  logic             mem_valid_out = 1'b0;
  logic [DW-1:0]    mem_Data_out = '0;

  mem_arb_ctrl #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .rvalid(rvalid), .rerr(rerr), .rdata(rdata), .busy(busy),
    .mem_EN(mem_EN), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_add(mem_add), .mem_Data_in(mem_Data_in),
    .mem_valid_out(mem_valid_out), .mem_Data_out(mem_Data_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural memory: fixed read latency, optional mute, optional stray valid.
  logic [DW-1:0] memarr [16];
  int            rd_lat = 2;
  bit            mute = 1'b0;
  bit            stray_go = 1'b0;
  logic [DW-1:0] stray_data = '0;
  int            pend_cnt = 0;
  logic [DW-1:0] pend_data = '0;

  initial begin
    for (int i = 0; i < 16; i++) memarr[i] = 32'h1000_0000 + 32'(i);
    memarr[5] = 32'h1234_5678;
    forever begin
      @(posedge clk);
      #2;
      mem_valid_out = 1'b0;
      if (stray_go) begin
        mem_valid_out = 1'b1;
        mem_Data_out  = stray_data;
        stray_go      = 1'b0;
      end
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          mem_valid_out = 1'b1;
          mem_Data_out  = pend_data;
        end
      end
      if (mem_EN && mem_wr_en) memarr[mem_add] = mem_Data_in;
      if (mem_EN && mem_rd_en && !mute) begin
        pend_cnt  = rd_lat;
        pend_data = memarr[mem_add];
      end
    end
  end

  // Timeline model: a grant at edge g puts the memory strobe after edge g+1; a write frees
  // the arbiter for edge g+2, a read stays open until valid (or the timeout edge).
  int               cyc = 0;
  int               g_edge = -10;
  bit               pref = 1'b0;
  bit               rd_open = 1'b0;
  bit               g_id = 1'b0;
  bit               g_we = 1'b0;
  logic [DEPTH-1:0] g_addr = '0;
  logic [DW-1:0]    g_data = '0;
  logic [1:0]       e_gnt = 2'b00, e_rvalid = 2'b00, e_rerr = 2'b00;
  logic             e_busy = 1'b0, e_en = 1'b0, e_wr = 1'b0, e_rd = 1'b0;
  logic [DEPTH-1:0] e_add = '0;
  logic [DW-1:0]    e_din = '0, e_rdata = '0;

  task automatic model_step();
    if (rst) begin
      g_edge = -10; pref = 1'b0; rd_open = 1'b0;
      e_gnt = 2'b00; e_rvalid = 2'b00; e_rerr = 2'b00;
      e_busy = 1'b0; e_en = 1'b0; e_wr = 1'b0; e_rd = 1'b0;
      e_add = '0; e_din = '0; e_rdata = '0;
    end else begin
      cyc++;
      e_gnt = 2'b00; e_rvalid = 2'b00; e_rerr = 2'b00;
      e_en = 1'b0; e_wr = 1'b0; e_rd = 1'b0;
      if (cyc == g_edge + 1) begin
        e_en = 1'b1; e_wr = g_we; e_rd = !g_we;
        e_add = g_addr; e_din = g_data;
        rd_open = !g_we; e_busy = !g_we;
      end else if (rd_open) begin
        if (mem_valid_out) begin
          e_rdata = mem_Data_out;
          e_rvalid = g_id ? 2'b10 : 2'b01;
          rd_open = 1'b0; e_busy = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cyc - (g_edge + 1) == int'(TIMEOUT)) begin
          e_rerr = g_id ? 2'b10 : 2'b01;
          rd_open = 1'b0; e_busy = 1'b0;
        end
`endif
      end else if (req != 2'b00) begin
        g_id   = (req == 2'b11) ? pref : req[1];
        pref   = !g_id;
        g_edge = cyc;
        g_we   = we[g_id];
        g_addr = g_id ? addr1 : addr0;
        g_data = g_id ? wdata1 : wdata0;
        e_gnt  = g_id ? 2'b10 : 2'b01;
        e_busy = 1'b1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("cyc_gnt",     32'(gnt),         32'(e_gnt));
      chk("cyc_rvalid",  32'(rvalid),      32'(e_rvalid));
      chk("cyc_rerr",    32'(rerr),        32'(e_rerr));
      chk("cyc_rdata",   rdata,            e_rdata);
      chk("cyc_busy",    32'(busy),        32'(e_busy));
      chk("cyc_mem_en",  32'(mem_EN),      32'(e_en));
      chk("cyc_mem_wr",  32'(mem_wr_en),   32'(e_wr));
      chk("cyc_mem_rd",  32'(mem_rd_en),   32'(e_rd));
      chk("cyc_mem_add", 32'(mem_add),     32'(e_add));
      chk("cyc_mem_din", mem_Data_in,      e_din);
    end
  end

  task automatic wait_gnt(input int id);
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (gnt[id]) ok = 1'b1;
    end
    if (!ok) chk("gnt_wait", 32'(gnt), 32'(id == 1 ? 2'b10 : 2'b01));
  endtask

  task automatic wait_rv(output int n, output logic [1:0] rv);
    rv = 2'b00;
    n  = 0;
    for (int i = 1; i <= 60 && rv == 2'b00; i++) begin
      @(negedge clk);
      if (rvalid != 2'b00) begin
        rv = rvalid;
        n  = i;
      end
    end
    if (rv == 2'b00) chk("rvalid_wait", 32'(rv), 32'h1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},     32'(gnt),       32'h0);
    chk({tag, "_rvalid"},  32'(rvalid),    32'h0);
    chk({tag, "_rerr"},    32'(rerr),      32'h0);
    chk({tag, "_busy"},    32'(busy),      32'h0);
    chk({tag, "_mem_en"},  32'(mem_EN),    32'h0);
    chk({tag, "_mem_wr"},  32'(mem_wr_en), 32'h0);
    chk({tag, "_mem_rd"},  32'(mem_rd_en), 32'h0);
    chk({tag, "_mem_add"}, 32'(mem_add),   32'h0);
    chk({tag, "_mem_din"}, mem_Data_in,    32'h0);
    chk({tag, "_rdata"},   rdata,          32'h0);
  endtask

  initial begin
    int         n;
    int         k;
    logic [1:0] rv;
    logic [1:0] seen;
    logic [1:0] order [4];
    int         at [4];
    logic [DW-1:0] rd_got [2];
    logic [1:0]    rv_got [2];

    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // Single write from requester 0.
    req = 2'b01; we = 2'b01; addr0 = 4'd3; wdata0 = 32'hDEAD_BEEF;
    wait_gnt(0);
    chk("wr_gnt", 32'(gnt), 32'h1);
    req = 2'b00;
    @(negedge clk);
    chk("wr_mem_en", 32'(mem_EN), 32'h1);
    chk("wr_mem_wr", 32'(mem_wr_en), 32'h1);
    chk("wr_mem_rd", 32'(mem_rd_en), 32'h0);
    chk("wr_mem_add", 32'(mem_add), 32'h3);
    chk("wr_mem_din", mem_Data_in, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("wr_turnaround_busy", 32'(busy), 32'h0);

    // Single read from requester 1, memory latency 2.
    req = 2'b10; we = 2'b00; addr1 = 4'd5; rd_lat = 2;
    wait_gnt(1);
    req = 2'b00;
    @(negedge clk);
    chk("rd_mem_rd", 32'(mem_rd_en), 32'h1);
    wait_rv(n, rv);
    chk("rd_rvalid", 32'(rv), 32'h2);
    chk("rd_rdata", rdata, 32'h1234_5678);
    chk("rd_latency", 32'(n), 32'd3);

    // Write by requester 1 then read back by requester 0.
    req = 2'b10; we = 2'b10; addr1 = 4'd7; wdata1 = 32'hCAFE_F00D;
    wait_gnt(1);
    req = 2'b00;
    @(negedge clk);
    req = 2'b01; we = 2'b00; addr0 = 4'd7;
    wait_gnt(0);
    req = 2'b00;
    wait_rv(n, rv);
    chk("rt_rvalid", 32'(rv), 32'h1);
    chk("rt_rdata", rdata, 32'hCAFE_F00D);

    // Stray memory valid while idle is ignored.
    repeat (2) @(negedge clk);
    stray_data = 32'h5555_AAAA; stray_go = 1'b1;
    seen = 2'b00;
    repeat (4) begin
      @(negedge clk);
      seen |= rvalid;
    end
    chk("stray_rvalid", 32'(seen), 32'h0);
    chk("stray_rdata", rdata, 32'hCAFE_F00D);

    // Both requesting writes: alternate starting with requester 0, 2-cycle spacing.
    do_reset();
    req = 2'b11; we = 2'b11; addr0 = 4'd1; addr1 = 4'd2;
    wdata0 = 32'hA0A0_0001; wdata1 = 32'hB0B0_0002;
    for (int i = 0; i < 4; i++) begin order[i] = 2'b00; at[i] = 0; end
    k = 0;
    for (int i = 0; i < 40 && k < 4; i++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin
        order[k] = gnt;
        at[k] = i;
        k++;
      end
    end
    req = 2'b00;
    chk("rr_gnt0", 32'(order[0]), 32'h1);
    chk("rr_gnt1", 32'(order[1]), 32'h2);
    chk("rr_gnt2", 32'(order[2]), 32'h1);
    chk("rr_gnt3", 32'(order[3]), 32'h2);
    chk("rr_spacing", 32'(at[1] - at[0]), 32'd2);

    // Both requesting reads, latency 1.
    repeat (2) @(negedge clk);
    rd_lat = 1;
    req = 2'b11; we = 2'b00; addr0 = 4'd4; addr1 = 4'd6;
    k = 0;
    for (int i = 0; i < 60 && k < 2; i++) begin
      @(negedge clk);
      if (gnt[0]) req[0] = 1'b0;
      if (gnt[1]) req[1] = 1'b0;
      if (rvalid != 2'b00) begin
        rv_got[k] = rvalid;
        rd_got[k] = rdata;
        k++;
      end
    end
    req = 2'b00;
    chk("rr_rd_count", 32'(k), 32'd2);
    chk("rr_rd_first", 32'(rv_got[0]), 32'h1);
    chk("rr_rd_first_data", rd_got[0], 32'h1000_0004);
    chk("rr_rd_second", 32'(rv_got[1]), 32'h2);
    chk("rr_rd_second_data", rd_got[1], 32'h1000_0006);

    // Request inputs changing while a write is in flight do not disturb it.
    repeat (2) @(negedge clk);
    req = 2'b01; we = 2'b01; addr0 = 4'd9; wdata0 = 32'h0BAD_F00D;
    wait_gnt(0);
    req = 2'b10; we = 2'b11; addr0 = 4'd10; wdata0 = 32'h0;
    addr1 = 4'd11; wdata1 = 32'h1111_2222;
    @(negedge clk);
    chk("inflight_en", 32'(mem_EN), 32'h1);
    chk("inflight_add", 32'(mem_add), 32'h9);
    chk("inflight_din", mem_Data_in, 32'h0BAD_F00D);
    wait_gnt(1);
    req = 2'b00;
    @(negedge clk);
    chk("next_add", 32'(mem_add), 32'hB);
    chk("next_din", mem_Data_in, 32'h1111_2222);

    // Read with no memory response.
    repeat (2) @(negedge clk);
    mute = 1'b1;
    req = 2'b10; we = 2'b00; addr1 = 4'd5;
    wait_gnt(1);
    req = 2'b00;
    @(negedge clk);
    chk("norsp_mem_rd", 32'(mem_rd_en), 32'h1);
`ifdef ARB_TIMEOUT_EN
    begin
      bit found = 1'b0;
      k = 0;
      for (int i = 1; i <= 30 && !found; i++) begin
        @(negedge clk);
        if (rerr != 2'b00) begin
          found = 1'b1;
          k = i;
          chk("to_rerr", 32'(rerr), 32'h2);
          chk("to_busy", 32'(busy), 32'h0);
          chk("to_rvalid", 32'(rvalid), 32'h0);
        end
      end
      chk("to_cycles", 32'(k), 32'(TIMEOUT));
    end
`else
    seen = 2'b00;
    repeat (20) begin
      @(negedge clk);
      seen |= rerr;
    end
    chk("nto_busy", 32'(busy), 32'h1);
    chk("nto_rerr", 32'(seen), 32'h0);
    stray_data = 32'h7777_8888; stray_go = 1'b1;
    wait_rv(n, rv);
    chk("nto_rvalid", 32'(rv), 32'h2);
    chk("nto_rdata", rdata, 32'h7777_8888);
`endif
    mute = 1'b0;

    // Reset during a read: everything clears at once, the late memory response is dropped.
    repeat (2) @(negedge clk);
    rd_lat = 6;
    req = 2'b01; we = 2'b00; addr0 = 4'd5;
    wait_gnt(0);
    req = 2'b00;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'h1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 2'b00;
    repeat (8) begin
      @(negedge clk);
      seen |= rvalid;
    end
    chk("post_rst_rvalid", 32'(seen), 32'h0);
    chk("post_rst_busy", 32'(busy), 32'h0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
